// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx #(
    parameter int unsigned SIZE         = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic [SIZE-1:0] data_out,
    output logic            rx_valid,
    output logic            rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] HalfCnt = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LastCnt = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LastIdx = IW'(SIZE - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
`ifdef UART_RX_PARITY_EN
        StParity   = 3'd5,
`endif
        StWaitIdle = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SIZE-1:0] shift_q, shift_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at its midpoint was a glitch.
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[SIZE-1:1]};
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LastCnt) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s_q ^ (^shift_q);
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end
`endif
                    else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a scoreboard queue of expected pulses is filled as
// frames are driven and drained by a monitor that checks each rx_valid/error pulse.
module tb_uart_rx;

    localparam int unsigned SIZE = 8;
    localparam int unsigned CPB  = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    localparam int unsigned BUSY_EXP = (SIZE + 1 + PBITS) * CPB + CPB / 2;

    localparam int KValid = 0;
    localparam int KFrame = 1;
    localparam int KParity = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       perr;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       pulse_prev = 1'b0;
    int         busy_cnt = 0;

    uart_rx #(
        .SIZE         (SIZE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (perr),
`endif
        .frame_err  (frame_err)
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed=%0d pending expected=0", tag, sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rx_busy) busy_cnt++;
    end

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        logic any;
        if (!rst_n) begin
            prev_data  = data_out;
            pulse_prev = 1'b0;
        end else begin
            any = rx_valid | frame_err | perr;
            if (data_out !== prev_data) begin
                checks++;
                assert (rx_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL data_change_no_valid observed=%0b expected=1", rx_valid);
                end
            end
            prev_data = data_out;
            if (any) begin
                checks++;
                assert (!pulse_prev) else begin
                    errors++;
                    $error("FAIL pulse_width observed=2+ cycles expected=1");
                end
                checks++;
                assert ($countones({rx_valid, frame_err, perr}) == 1) else begin
                    errors++;
                    $error("FAIL pulse_exclusive observed=%b expected=onehot",
                           {rx_valid, frame_err, perr});
                end
                kind = rx_valid ? KValid : (frame_err ? KFrame : KParity);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_pulse observed=kind%0d data=%0h expected=none",
                           kind, data_out);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (kind === e.kind) else begin
                        errors++;
                        $error("FAIL pulse_kind observed=%0d expected=%0d", kind, e.kind);
                    end
                    checks++;
                    assert (data_out === e.data) else begin
                        errors++;
                        $error("FAIL pulse_data observed=%0h expected=%0h", data_out, e.data);
                    end
                end
            end
            pulse_prev = any;
        end
    end

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] mid;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        bytes[3] = 8'h80;

        // Reset then long idle.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_perr", 32'(perr), 32'h0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_busy", 32'(rx_busy), 32'h0);
        check("idle_data", 32'(data_out), 32'h0);

        // Single frame and busy duration.
        busy_cnt = 0;
        push(KValid, 8'hA5);
        last_good = 8'hA5;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_drain("single_a5");
        repeat (CPB) @(negedge clk);
        checks++;
        assert (busy_cnt >= BUSY_EXP - 2 && busy_cnt <= BUSY_EXP + 2) else begin
            errors++;
            $error("FAIL busy_len observed=%0d expected=%0d", busy_cnt, BUSY_EXP);
        end
        check("a5_data", 32'(data_out), 32'hA5);

        // Back-to-back frames, no idle gap.
        for (int i = 0; i < 4; i++) begin
            push(KValid, bytes[i]);
            last_good = bytes[i];
            send_frame(bytes[i], 1'b1, 1'b0);
        end
        wait_drain("b2b");
        check("b2b_last", 32'(data_out), 32'h80);

        // Short low glitch is rejected.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * 2) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'h0);
        check("glitch_data", 32'(data_out), 32'h80);

        // Framing error with line held low afterwards.
        push(KFrame, last_good);
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        wait_drain("ferr");
        check("ferr_hold_busy", 32'(rx_busy), 32'h1);
        check("ferr_data", 32'(data_out), 32'h80);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("ferr_release_busy", 32'(rx_busy), 32'h0);
        push(KValid, 8'h12);
        last_good = 8'h12;
        send_frame(8'h12, 1'b1, 1'b0);
        wait_drain("after_ferr");
        check("after_ferr_data", 32'(data_out), 32'h12);

        // Reset in the middle of data bit 4 of 0x77.
        mid = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(mid[i]);
        rx = mid[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(rx_busy), 32'h0);
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("postrst_busy", 32'(rx_busy), 32'h0);
        push(KValid, 8'h11);
        last_good = 8'h11;
        send_frame(8'h11, 1'b1, 1'b0);
        wait_drain("after_rst");
        check("after_rst_data", 32'(data_out), 32'h11);

`ifdef UART_RX_PARITY_EN
        push(KParity, last_good);
        send_frame(8'h11, 1'b1, 1'b1);
        wait_drain("parity");
        check("parity_data", 32'(data_out), 32'h11);
`endif

        repeat (2 * CPB) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART project, sitting directly downstream of the `transmission` TX block. It consumes the `tx` line, recovers 8N1 frames (optionally 8E1) by mid-bit sampling, and presents each byte as a one-cycle valid pulse. It is the receive half used for TX/RX loopback benches.

## Interface
- `SIZE`, 8: data bits per frame, sent LSB first.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range ≥ 4; must match the TX bit period.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `rx`  in  1  serial line, idle high; asynchronous to `clk`.
- `data_out`  out  SIZE  last received byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse: `data_out` was updated with a good frame.
- `rx_busy`  out  1  high from start-bit detection until return to IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- Input: 2-flop synchronizer on `rx`, reset to 1. All decisions use the synchronized value `rx_s`.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide and bit index is `$clog2(SIZE+1)` bits wide; both reset to 0.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: when `rx_s`==0, go to START and clear the counter.
- START: at count `CLKS_PER_BIT/2-1` (mid start bit), sample `rx_s`.
  - If 1, treat as a glitch: return to IDLE with no error pulse.
  - If 0, clear the counter and go to DATA.
- DATA: at each count `CLKS_PER_BIT-1`, shift `rx_s` into bit[index] (LSB first). After SIZE bits, go to PARITY (macro) or STOP.
- PARITY: after one bit period, compare the sample against the XOR of the data bits (even parity) and record a mismatch.
- STOP: after one bit period, sample `rx_s`.
  - If 1 and no parity mismatch: load `data_out`, pulse `rx_valid`, go to IDLE.
  - If 1 with a parity mismatch: pulse `parity_err`; do not update `data_out`; go to IDLE.
  - If 0: pulse `frame_err`; do not update `data_out`; go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`==1 (break condition), then go to IDLE. This prevents a held-low line from being re-detected as a start bit.
- `rx_busy` = (state != IDLE).
- Reset mid-frame: outputs and FSM return to reset values immediately; the partial frame is discarded. After `rst_n` deasserts, the block waits for a fresh falling edge.

## Timing
- Reset values: `data_out`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `parity_err`=0, state=IDLE.
- Start detection lags the line edge by 2 cycles (synchronizer) plus 1 cycle (IDLE→START).
- All samples are taken at the middle of each bit, ±1 cycle.
- `rx_valid`, `frame_err` and `parity_err` are registered, mutually exclusive, and last exactly 1 cycle. They rise on the cycle after the mid-stop-bit sample.
- `data_out` changes only on the same edge that raises `rx_valid`.
- Back-to-back frames: the FSM returns to IDLE half a bit before the end of the stop bit, so a start bit that immediately follows is caught with no gaps and no lost frames.
- No backpressure exists. The consumer must take `data_out` before the next `rx_valid`, which is at least (SIZE+2)·CLKS_PER_BIT cycles away.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start + SIZE data + 1 even-parity bit + stop.
  - PARITY state and the `parity_err` port exist.
- `UART_RX_PARITY_EN` not defined:
  - Frame is start + SIZE data + stop (8N1).
  - No PARITY state and no `parity_err` port.
  - Matches the current `transmission` framing.

## Test plan
- Reset then idle: with `rst_n`=0 for 10 cycles then released and `rx`=1 for 1000 cycles, all outputs stay 0 and `rx_busy`=0.
- Single frame 0xA5 at CLKS_PER_BIT=16: `rx_valid` pulses once, `data_out`=0xA5, `frame_err`=0, `rx_busy` high for about 152 cycles.
- Loopback with `transmission` for bytes 0x00, 0xFF, 0x55, 0x80 back-to-back: four `rx_valid` pulses in order, with matching `data_out` values.
- Glitch: a 4-cycle low pulse on `rx` returns the FSM to IDLE; no `rx_valid` and no `frame_err`.
- Framing error: send 0x3C with the stop bit forced low and `rx` held low for 3 bit times. Required: a single `frame_err` pulse, `data_out` unchanged, no restart until `rx` returns high, and a following 0x12 frame is received correctly.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of 0x77. Outputs clear immediately, with no `rx_valid`. The next frame 0x11 is received correctly. With the macro defined, 0x11 sent with a wrong parity bit gives `parity_err`=1 for 1 cycle and no `rx_valid`.
